// File: rtl/interrupt_priority_scheduler.sv
// 8-level interrupt priority scheduler: IRR/ISR tracking with rotating circular priority,
// fully nested eligibility and a two-pulse INTA acknowledge handshake.
module interrupt_priority_scheduler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] interrupt_mask,
  input  logic       level_or_edge_triggered_config,
  input  logic [2:0] priority_rotate,
  input  logic       auto_eoi_config,
  input  logic [7:0] end_of_interrupt,
  input  logic       interrupt_acknowledge_n,
  output logic       interrupt_to_cpu,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] vector_level,
  output logic       vector_valid,
  output logic       spurious
);

  typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

  state_t     state, state_nxt;
  logic       prev_inta_n, inta_fall, inta_rise;
  logic [7:0] ir_prev, irr, isr, irr_nxt, isr_nxt;
  logic [7:0] edge_set, ack1_set, aeoi_clear;
  logic [3:0] isr_rank;
  logic [2:0] winner;
  logic       any_elig, ack1_entry, aeoi_fire, int_nxt;

  // Level holding priority slot k (0 = highest) for a given rotation.
  function automatic logic [2:0] level_at(input logic [2:0] rot, input int k);
    return rot + 3'd1 + 3'(k);
  endfunction

  assign inta_fall = prev_inta_n & ~interrupt_acknowledge_n;
  assign inta_rise = ~prev_inta_n & interrupt_acknowledge_n;

  // Scan from lowest to highest priority so the last hit is the highest one.
  always_comb begin
    isr_rank                 = 4'd8;
    highest_level_in_service = 8'h00;
    winner                   = 3'd0;
    any_elig                 = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (isr[level_at(priority_rotate, k)]) begin
        isr_rank                 = 4'(k);
        highest_level_in_service = 8'd1 << level_at(priority_rotate, k);
      end
    end
    for (int k = 7; k >= 0; k--) begin
      if (irr[level_at(priority_rotate, k)] && !interrupt_mask[level_at(priority_rotate, k)]
          && (4'(k) < isr_rank)) begin
        winner   = level_at(priority_rotate, k);
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inta_fall) state_nxt = ACK1;
               else if (any_elig) state_nxt = PEND;
      PEND:    if (inta_fall) state_nxt = ACK1;
               else if (!any_elig && interrupt_acknowledge_n) state_nxt = IDLE;
      ACK1:    if (inta_fall) state_nxt = ACK2;
      ACK2:    if (inta_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack1_entry   = ((state == IDLE) || (state == PEND)) && inta_fall;
    aeoi_fire    = (state == ACK2) && inta_rise && auto_eoi_config && !spurious;
    int_nxt      = (state_nxt == PEND);
    vector_valid = (state == ACK2) && !interrupt_acknowledge_n;
  end

  // An edge set and a same-cycle ACK1 set both override the clears.
  always_comb begin
    edge_set   = interrupt_request & ~ir_prev;
    ack1_set   = (ack1_entry && any_elig) ? (8'd1 << winner) : 8'h00;
    aeoi_clear = aeoi_fire ? (8'd1 << vector_level) : 8'h00;
    irr_nxt    = level_or_edge_triggered_config ? interrupt_request
                                                : ((irr & ~ack1_set) | edge_set);
    isr_nxt    = (isr & ~end_of_interrupt & ~aeoi_clear) | ack1_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_inta_n      <= 1'b1;
      ir_prev          <= 8'h00;
      irr              <= 8'h00;
      isr              <= 8'h00;
      interrupt_to_cpu <= 1'b0;
      vector_level     <= 3'd0;
      spurious         <= 1'b0;
    end else begin
      prev_inta_n      <= interrupt_acknowledge_n;
      ir_prev          <= interrupt_request;
      irr              <= irr_nxt;
      isr              <= isr_nxt;
      interrupt_to_cpu <= int_nxt;
      if (ack1_entry) begin
        vector_level <= any_elig ? winner : 3'd7;
        spurious     <= ~any_elig;
      end
    end
  end

  assign interrupt_request_register = irr;
  assign in_service_register        = isr;

endmodule

// File: tb/tb_interrupt_priority_scheduler.sv
// Directed bench for interrupt_priority_scheduler: a table of full request/acknowledge
// transactions plus hand-written sequences for nesting, EOI, masking and reset abort.
module tb_interrupt_priority_scheduler;

  logic       clk;
  logic       reset_n;
  logic [7:0] interrupt_request;
  logic [7:0] interrupt_mask;
  logic       level_or_edge_triggered_config;
  logic [2:0] priority_rotate;
  logic       auto_eoi_config;
  logic [7:0] end_of_interrupt;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] vector_level;
  logic       vector_valid;
  logic       spurious;

  int errors = 0;
  int checks = 0;

  interrupt_priority_scheduler dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .interrupt_request              (interrupt_request),
    .interrupt_mask                 (interrupt_mask),
    .level_or_edge_triggered_config (level_or_edge_triggered_config),
    .priority_rotate                (priority_rotate),
    .auto_eoi_config                (auto_eoi_config),
    .end_of_interrupt               (end_of_interrupt),
    .interrupt_acknowledge_n        (interrupt_acknowledge_n),
    .interrupt_to_cpu               (interrupt_to_cpu),
    .interrupt_request_register     (interrupt_request_register),
    .in_service_register            (in_service_register),
    .highest_level_in_service       (highest_level_in_service),
    .vector_level                   (vector_level),
    .vector_valid                   (vector_valid),
    .spurious                       (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lvl_mode;
    logic [7:0] mask;
    logic [2:0] rot;
    logic [7:0] ir;
    logic       aeoi;
    logic       exp_int;
    logic [2:0] exp_vec;
    logic       exp_spur;
    logic [7:0] exp_isr_a2;
    logic [7:0] exp_isr_end;
    logic [7:0] exp_irr_end;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n                        = 1'b0;
    interrupt_request              = 8'h00;
    interrupt_mask                 = 8'h00;
    level_or_edge_triggered_config = 1'b0;
    priority_rotate                = 3'd7;
    auto_eoi_config                = 1'b0;
    end_of_interrupt               = 8'h00;
    interrupt_acknowledge_n        = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Raise the request lines for one cycle; the request becomes visible to the CPU two edges later.
  task automatic raise_ir(input logic [7:0] bits, input logic hold);
    interrupt_request = bits;
    tick();
    if (!hold) interrupt_request = 8'h00;
    tick();
  endtask

  task automatic ack_seq(input string tag, input logic [2:0] exp_vec, input logic exp_spur,
                         input logic [7:0] exp_isr_a2);
    interrupt_acknowledge_n = 1'b0;
    tick();
    check({tag, ".int_ack1"}, {7'd0, interrupt_to_cpu}, 8'h00);
    check({tag, ".vec"}, {5'd0, vector_level}, {5'd0, exp_vec});
    check({tag, ".spur"}, {7'd0, spurious}, {7'd0, exp_spur});
    check({tag, ".vv_ack1"}, {7'd0, vector_valid}, 8'h00);
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    check({tag, ".vv_ack2"}, {7'd0, vector_valid}, 8'h01);
    check({tag, ".isr_ack2"}, in_service_register, exp_isr_a2);
    interrupt_acknowledge_n = 1'b1;
    tick();
    check({tag, ".vv_idle"}, {7'd0, vector_valid}, 8'h00);
  endtask

  initial begin
    //          lvl  mask   rot   ir     aeoi int vec spur isr_a2 isr_end irr_end
    tbl[0] = '{1'b0, 8'h00, 3'd7, 8'h28, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 8'h08, 8'h20};
    tbl[1] = '{1'b0, 8'h00, 3'd4, 8'h21, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 8'h20, 8'h01};
    tbl[2] = '{1'b0, 8'h00, 3'd7, 8'h21, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'h01, 8'h20};
    tbl[3] = '{1'b0, 8'h00, 3'd7, 8'h02, 1'b1, 1'b1, 3'd1, 1'b0, 8'h02, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 8'h00, 3'd2, 8'hC1, 1'b0, 1'b1, 3'd6, 1'b0, 8'h40, 8'h40, 8'hC1};
    tbl[5] = '{1'b0, 8'hFF, 3'd7, 8'h10, 1'b0, 1'b0, 3'd7, 1'b1, 8'h00, 8'h00, 8'h10};
    tbl[6] = '{1'b0, 8'h08, 3'd7, 8'h0C, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 8'h04, 8'h08};
    tbl[7] = '{1'b0, 8'h00, 3'd0, 8'h81, 1'b0, 1'b1, 3'd7, 1'b0, 8'h80, 8'h80, 8'h01};

    do_reset();
    check("rst.int",  {7'd0, interrupt_to_cpu}, 8'h00);
    check("rst.irr",  interrupt_request_register, 8'h00);
    check("rst.isr",  in_service_register, 8'h00);
    check("rst.hlis", highest_level_in_service, 8'h00);
    check("rst.vec",  {5'd0, vector_level}, 8'h00);
    check("rst.vv",   {7'd0, vector_valid}, 8'h00);
    check("rst.spur", {7'd0, spurious}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      do_reset();
      level_or_edge_triggered_config = tbl[i].lvl_mode;
      interrupt_mask                 = tbl[i].mask;
      priority_rotate                = tbl[i].rot;
      auto_eoi_config                = tbl[i].aeoi;
      raise_ir(tbl[i].ir, tbl[i].lvl_mode);
      check({tag, ".int"}, {7'd0, interrupt_to_cpu}, {7'd0, tbl[i].exp_int});
      ack_seq(tag, tbl[i].exp_vec, tbl[i].exp_spur, tbl[i].exp_isr_a2);
      check({tag, ".isr_end"}, in_service_register, tbl[i].exp_isr_end);
      check({tag, ".hlis"}, highest_level_in_service, tbl[i].exp_isr_end);
      check({tag, ".irr_end"}, interrupt_request_register, tbl[i].exp_irr_end);
      interrupt_request = 8'h00;
    end

    // Nested request held off until EOI of the level in service.
    do_reset();
    raise_ir(8'h28, 1'b0);
    ack_seq("eoi", 3'd3, 1'b0, 8'h08);
    tick();
    check("eoi.int_held", {7'd0, interrupt_to_cpu}, 8'h00);
    end_of_interrupt = 8'h08;
    tick();
    end_of_interrupt = 8'h00;
    check("eoi.isr", in_service_register, 8'h00);
    tick();
    check("eoi.int_after", {7'd0, interrupt_to_cpu}, 8'h01);

    // Edge set wins over ACK1 clear; lower priority stays blocked until EOI.
    do_reset();
    raise_ir(8'h04, 1'b0);
    interrupt_acknowledge_n = 1'b0;
    interrupt_request       = 8'h04;
    tick();
    interrupt_request       = 8'h00;
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    interrupt_acknowledge_n = 1'b1;
    tick();
    check("nest.isr",  in_service_register, 8'h04);
    check("nest.irr",  interrupt_request_register, 8'h04);
    check("nest.hlis", highest_level_in_service, 8'h04);
    raise_ir(8'h40, 1'b0);
    tick();
    check("nest.int_blocked", {7'd0, interrupt_to_cpu}, 8'h00);
    check("nest.irr2", interrupt_request_register, 8'h44);
    end_of_interrupt = 8'h04;
    tick();
    end_of_interrupt = 8'h00;
    check("nest.isr_eoi", in_service_register, 8'h00);
    check("nest.int_eoi", {7'd0, interrupt_to_cpu}, 8'h00);
    tick();
    check("nest.int_pend", {7'd0, interrupt_to_cpu}, 8'h01);

    // Request masked after INT: spurious ack, then a clean ack with config changes mid-sequence.
    do_reset();
    raise_ir(8'h04, 1'b0);
    check("spur.int", {7'd0, interrupt_to_cpu}, 8'h01);
    interrupt_mask = 8'h04;
    tick();
    check("spur.int_drop", {7'd0, interrupt_to_cpu}, 8'h00);
    ack_seq("spur", 3'd7, 1'b1, 8'h00);
    check("spur.isr", in_service_register, 8'h00);
    check("spur.irr", interrupt_request_register, 8'h04);
    interrupt_mask = 8'h00;
    tick();
    tick();
    check("spur.int_again", {7'd0, interrupt_to_cpu}, 8'h01);
    interrupt_acknowledge_n = 1'b0;
    tick();
    check("latch.vec1", {5'd0, vector_level}, 8'h02);
    check("latch.spur", {7'd0, spurious}, 8'h00);
    priority_rotate = 3'd3;
    interrupt_mask  = 8'hFF;
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    check("latch.vv",   {7'd0, vector_valid}, 8'h01);
    check("latch.vec2", {5'd0, vector_level}, 8'h02);
    check("latch.isr",  in_service_register, 8'h04);
    interrupt_acknowledge_n = 1'b1;
    tick();
    check("latch.vec3", {5'd0, vector_level}, 8'h02);

    // Reset asserted during ACK2 aborts at once; a fresh request afterwards acks normally.
    do_reset();
    raise_ir(8'h02, 1'b0);
    interrupt_acknowledge_n = 1'b0;
    tick();
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    check("abort.vv_pre", {7'd0, vector_valid}, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort.int",  {7'd0, interrupt_to_cpu}, 8'h00);
    check("abort.vv",   {7'd0, vector_valid}, 8'h00);
    check("abort.spur", {7'd0, spurious}, 8'h00);
    check("abort.vec",  {5'd0, vector_level}, 8'h00);
    check("abort.isr",  in_service_register, 8'h00);
    check("abort.irr",  interrupt_request_register, 8'h00);
    check("abort.hlis", highest_level_in_service, 8'h00);
    interrupt_acknowledge_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    raise_ir(8'h01, 1'b0);
    check("abort.int_new", {7'd0, interrupt_to_cpu}, 8'h01);
    ack_seq("abort", 3'd0, 1'b0, 8'h01);
    check("abort.isr_end", in_service_register, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_priority_scheduler.md
INTERRUPT_PRIORITY_SCHEDULER -- requirements
Module: interrupt_priority_scheduler

Interface
REQ-001 The block SHALL have these ports; clock and reset first:
- clk  input  1  single block clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- interrupt_request  input  8  raw IR7..IR0 lines.
- interrupt_mask  input  8  IMR; 1 = level masked.
- level_or_edge_triggered_config  input  1  1 = level mode, 0 = edge mode.
- priority_rotate  input  3  lowest-priority level; highest is priority_rotate+1 mod 8.
- auto_eoi_config  input  1  1 = clear ISR bit at end of acknowledge.
- end_of_interrupt  input  8  one-cycle pulse; set bits clear matching ISR bits.
- interrupt_acknowledge_n  input  1  INTA from CPU, active low.
- interrupt_to_cpu  output  1  INT request to CPU.
- interrupt_request_register  output  8  IRR.
- in_service_register  output  8  ISR.
- highest_level_in_service  output  8  one-hot highest-priority ISR bit, 0 if ISR empty.
- vector_level  output  3  acknowledged level.
- vector_valid  output  1  vector_level valid for data bus.
- spurious  output  1  last ACK1 found no eligible request.

Function
REQ-002 The block SHALL register interrupt_acknowledge_n into prev_inta_n each cycle; falling edge = prev_inta_n & ~interrupt_acknowledge_n; rising edge = ~prev_inta_n & interrupt_acknowledge_n.
REQ-003 In edge mode, IRR bit n SHALL set on a registered 0->1 of interrupt_request[n] and clear only when that level is latched at ACK1.
REQ-004 If an edge set and an ACK1 clear hit the same IRR bit in the same cycle, the set SHALL win.
REQ-005 In level mode, IRR SHALL equal interrupt_request registered each cycle; an ACK1 clear SHALL not apply.
REQ-006 Priority order SHALL be circular: priority_rotate+1 highest, priority_rotate lowest, with mod-8 wrap-around.
REQ-007 Level n SHALL be eligible when IRR[n]=1, interrupt_mask[n]=0, and n has strictly higher priority than every set ISR bit (fully nested).
REQ-008 The winner SHALL be the highest-priority eligible level; this is combinational from registered state.
REQ-009 The FSM SHALL have states IDLE, PEND, ACK1, ACK2.
REQ-010 FSM transitions:
- IDLE -> PEND when any level is eligible.
- PEND -> IDLE when none is eligible and INTA is high.
- PEND or IDLE -> ACK1 on an INTA falling edge.
- ACK1 -> ACK2 on the second INTA falling edge.
- ACK2 -> IDLE on an INTA rising edge.
REQ-011 On entry to ACK1, the block SHALL latch the winner into vector_level, set its ISR bit, and clear its IRR bit (edge mode).
- If nothing is eligible at that moment, the block SHALL latch vector_level=7, set spurious=1, and leave ISR unchanged.
REQ-012 interrupt_to_cpu SHALL be registered: 1 in PEND, 0 from ACK1 entry through return to IDLE.
REQ-013 vector_valid SHALL be 1 only in ACK2 while interrupt_acknowledge_n=0.
REQ-014 On the ACK2->IDLE transition with auto_eoi_config=1 and spurious=0, the block SHALL clear ISR[vector_level].
REQ-015 ISR update SHALL be next = (ISR & ~end_of_interrupt & ~aeoi_clear) | ack1_set; the set wins on the same bit.
REQ-016 highest_level_in_service SHALL be computed from the registered ISR using the REQ-006 order.
REQ-017 Changes to interrupt_mask or priority_rotate during ACK1/ACK2 SHALL NOT alter the latched vector_level.
REQ-018 spurious SHALL clear on the next ACK1 entry that finds an eligible level, and on reset.

Reset
REQ-019 While reset_n=0, asynchronously and regardless of clk:
- IRR, ISR, edge-detect history = 0x00.
- prev_inta_n = 1.
- FSM = IDLE.
- interrupt_to_cpu, vector_valid, spurious = 0.
- vector_level = 0.
REQ-020 Reset asserted mid-sequence (ACK1/ACK2) SHALL abort the sequence; after release, the block SHALL ignore interrupt_acknowledge_n until its next falling edge.

Verification
REQ-021 Edge mode, mask=0x00, rotate=7, pulse IR3 then IR5 -> INT=1; two INTA pulses give vector_level=3, ISR=0x08, IRR=0x20, INT re-asserts only after EOI=0x08.
REQ-022 rotate=4, IRR=0x21 unmasked -> ACK1 latches level 5 (priority 5 > 0); with rotate=7, the same IRR latches level 0.
REQ-023 ISR=0x04, IR6 rises -> INT stays 0; EOI=0x04 -> PEND next cycle, INT=1.
REQ-024 auto_eoi_config=1, IR1 acknowledged -> ISR=0x02 during ACK2, ISR=0x00 the cycle after the INTA rising edge.
REQ-025 INT asserted on IR2, IR2 masked before INTA -> ACK1 gives vector_level=7, spurious=1, ISR=0x00.
REQ-026 reset_n low during ACK2 -> all outputs at REQ-019 values immediately; a fresh IR0 edge afterwards yields a normal two-pulse sequence with vector_level=0.
